alu_issue_unit: RTL and testbench

Operand-issue front end for the KGP-RISC ALU. Accepts decoded ALU operations over a valid/ready handshake and drives `A`/`B`/`ALU_C` to the clocked ALU. It waits the ALU latency, captures `res`/`flags`, and returns the result over a second valid/ready handshake. It synthesises SUB as a two-pass COMP+ADD sequence and maintains the architectural flag register used by branch logic.

---
 rtl/alu_issue_unit.sv | 143 ++++++++++++++
 tb/tb_alu_issue_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: handshake front end that issues operands to a clocked ALU, waits its latency and returns the result
module alu_issue_unit #(
    parameter int ALU_LAT = 1
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  opcode,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic        use_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_c,
    input  logic [31:0] alu_res,
    input  logic [2:0]  alu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [2:0]  out_flags,
    output logic        out_err,
    output logic [2:0]  flag_reg
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SUB1, S_SUB2, S_DONE} state_t;
    localparam logic [2:0] LAT = 3'(ALU_LAT);
    localparam logic [2:0] OP_COMP = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;
    localparam logic [4:0] C_ADD = 5'b00000;
    localparam logic [4:0] C_COMP = 5'b10100;
    state_t      r_state;
    state_t      w_next;
    logic        r_ready;
    logic [2:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_tmp;
    logic [31:0] r_res;
    logic [2:0]  r_flags;
    logic [2:0]  r_flag_reg;
    logic        r_err;
    logic        w_accept;
    logic        w_zero;
    logic [4:0]  w_op_c;
    logic [31:0] w_b_in;
    assign w_accept  = (r_state == S_IDLE) && r_ready && in_valid;
    assign w_zero    = (r_cnt == 3'd0);
    assign w_b_in    = use_imm ? {{16{imm[15]}}, imm} : rt_val;
    assign w_op_c    = (r_op == 3'd0) ? C_ADD :
                       (r_op == OP_COMP) ? C_COMP :
                       (r_op == 3'd2) ? 5'b00001 :
                       (r_op == 3'd3) ? 5'b00010 :
                       (r_op == 3'd4) ? 5'b00011 : 5'b01111;
    assign in_ready  = r_ready;
    assign out_valid = (r_state == S_DONE);
    assign out_res   = r_res;
    assign out_flags = r_flags;
    assign out_err   = r_err;
    assign flag_reg  = r_flag_reg;
    // next-state selection and ALU bus drive; the bus is parked at zero outside the issuing states
    always_comb begin
        w_next = r_state;
        alu_a  = '0;
        alu_b  = '0;
        alu_c  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = (opcode == OP_SUB) ? S_SUB1 : (opcode == OP_ILL) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                alu_a  = (r_op == OP_COMP) ? 32'd0 : r_a;
                alu_b  = r_b;
                alu_c  = w_op_c;
                w_next = w_zero ? S_DONE : S_ISSUE;
            end
            S_SUB1: begin
                alu_b  = r_b;
                alu_c  = C_COMP;
                w_next = w_zero ? S_SUB2 : S_SUB1;
            end
            S_SUB2: begin
                alu_a  = r_a;
                alu_b  = r_tmp;
                alu_c  = C_ADD;
                w_next = w_zero ? S_DONE : S_SUB2;
            end
            S_DONE: begin
                w_next = out_ready ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    // state register; in_ready is registered so it stays low until the first edge after reset
    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
        end
    end
    // request latch, latency countdown and result/flag capture
    always_ff @(posedge clka) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_tmp      <= '0;
            r_res      <= '0;
            r_flags    <= '0;
            r_flag_reg <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_op  <= opcode;
            r_a   <= rs_val;
            r_b   <= w_b_in;
            r_cnt <= LAT;
            if (opcode == OP_ILL) begin
                r_res   <= '0;
                r_flags <= '0;
                r_err   <= 1'b1;
            end
        end else if (r_state == S_ISSUE || r_state == S_SUB1 || r_state == S_SUB2) begin
            if (!w_zero) begin
                r_cnt <= r_cnt - 3'd1;
            end else if (r_state == S_SUB1) begin
                r_tmp <= alu_res;
                r_cnt <= LAT;
            end else begin
                r_res      <= alu_res;
                r_flags    <= alu_flags;
                r_flag_reg <= alu_flags;
                r_err      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed self-checking bench for alu_issue_unit with a behavioural ALU
module tb_alu_issue_unit;
    logic        clka = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic        use_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_c;
    logic [31:0] alu_res;
    logic [2:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [2:0]  out_flags;
    logic        out_err;
    logic [2:0]  flag_reg;
    int checks = 0;
    int failures = 0;
    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_c;

    alu_issue_unit #(.ALU_LAT(1)) dut (
        .clka(clka), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .use_imm(use_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_res(alu_res), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
        .out_err(out_err), .flag_reg(flag_reg)
    );

    always #5 clka = ~clka;

    // behavioural ALU answering whatever the block drives on the bus
    always_comb begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = '0;
        m_c   = 1'b0;
        case (alu_c)
            5'b00000: begin m_res = m_sum[31:0]; m_c = m_sum[32]; end
            5'b10100: m_res = ~alu_b + 32'd1;
            5'b00001: m_res = alu_a & alu_b;
            5'b00010: m_res = alu_a ^ alu_b;
            5'b00011: m_res = alu_a << alu_b[4:0];
            5'b01111: m_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default:  m_res = '0;
        endcase
        alu_res   = m_res;
        alu_flags = {m_c, (m_res == 32'd0), m_res[31]};
    end

    task automatic tick;
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im, input logic ui);
        opcode   = op;
        rs_val   = a;
        rt_val   = b;
        imm      = im;
        use_imm  = ui;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            tick;
            chk(tag, {31'd0, out_valid}, {31'd0, i == n});
        end
    endtask

    task automatic handshake(input string tag);
        tick;
        chk({tag, "_vlow"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; opcode = 3'd0; rs_val = 32'hEAA52AA5; rt_val = 32'hEAA52AA5;
        imm = 16'h0; use_imm = 1'b0; out_ready = 1'b1;
        tick;
        tick;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_c", {27'd0, alu_c}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_flag_reg", {29'd0, flag_reg}, 32'd0);
        rst = 1'b0;
        tick;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_no_accept_a", alu_a, 32'd0);
        in_valid = 1'b0;

        issue(3'd0, 32'hEAA52AA5, 32'hEAA52AA5, 16'h0, 1'b0);
        chk("add_alu_c", {27'd0, alu_c}, 32'd0);
        chk("add_alu_a", alu_a, 32'hEAA52AA5);
        chk("add_alu_b", alu_b, 32'hEAA52AA5);
        chk("add_in_ready", {31'd0, in_ready}, 32'd0);
        wait_valid("add_valid", 2);
        chk("add_res", out_res, 32'hD54A554A);
        chk("add_flags", {29'd0, out_flags}, 32'd5);
        chk("add_flag_reg", {29'd0, flag_reg}, 32'd5);
        handshake("add");

        issue(3'd0, 32'd5, 32'h100, 16'hFFFE, 1'b1);
        chk("addi_alu_b", alu_b, 32'hFFFFFFFE);
        wait_valid("addi_valid", 2);
        chk("addi_res", out_res, 32'd3);
        chk("addi_flags", {29'd0, out_flags}, 32'd4);
        handshake("addi");

        issue(3'd4, 32'hEAA52AA5, 32'h1F, 16'h0002, 1'b1);
        chk("sll_alu_c", {27'd0, alu_c}, 32'd3);
        chk("sll_alu_b", alu_b, 32'd2);
        wait_valid("sll_valid", 2);
        chk("sll_res", out_res, 32'hAA94AA94);
        handshake("sll");

        issue(3'd5, 32'hEAA52AA5, 32'h1F, 16'h0002, 1'b1);
        chk("sra_alu_c", {27'd0, alu_c}, 32'h0F);
        wait_valid("sra_valid", 2);
        chk("sra_res", out_res, 32'hFAA94AA9);
        chk("sra_sign", {31'd0, out_flags[0]}, 32'd1);
        handshake("sra");

        issue(3'd6, 32'd5, 32'd7, 16'h0, 1'b0);
        chk("sub1_alu_c", {27'd0, alu_c}, 32'h14);
        chk("sub1_alu_a", alu_a, 32'd0);
        chk("sub1_alu_b", alu_b, 32'd7);
        tick;
        chk("sub_valid_e1", {31'd0, out_valid}, 32'd0);
        tick;
        chk("sub2_alu_c", {27'd0, alu_c}, 32'd0);
        chk("sub2_alu_a", alu_a, 32'd5);
        chk("sub2_alu_b", alu_b, 32'hFFFFFFF9);
        chk("sub_valid_e2", {31'd0, out_valid}, 32'd0);
        tick;
        chk("sub_valid_e3", {31'd0, out_valid}, 32'd0);
        tick;
        chk("sub_valid_e4", {31'd0, out_valid}, 32'd1);
        chk("sub_res", out_res, 32'hFFFFFFFE);
        chk("sub_flags", {29'd0, out_flags}, 32'd1);
        chk("sub_flag_reg", {29'd0, flag_reg}, 32'd1);
        handshake("sub");

        issue(3'd6, 32'd9, 32'd9, 16'h0, 1'b0);
        wait_valid("sub0_valid", 4);
        chk("sub0_res", out_res, 32'd0);
        chk("sub0_flags", {29'd0, out_flags}, 32'd6);
        chk("sub0_flag_reg", {29'd0, flag_reg}, 32'd6);
        handshake("sub0");

        out_ready = 1'b0;
        issue(3'd2, 32'hEAED2AA5, 32'hEAA52AA5, 16'h0, 1'b0);
        chk("and_alu_c", {27'd0, alu_c}, 32'd1);
        wait_valid("and_valid", 2);
        opcode = 3'd3; rs_val = 32'h12345678; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_res", out_res, 32'hEAA52AA5);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_flag_reg", {29'd0, flag_reg}, 32'd1);
            tick;
        end
        chk("bp_res_end", out_res, 32'hEAA52AA5);
        out_ready = 1'b1;
        in_valid = 1'b0;
        handshake("bp");
        chk("bp_no_accept_c", {27'd0, alu_c}, 32'd0);

        issue(3'd7, 32'd123, 32'd456, 16'h0, 1'b0);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_err", {31'd0, out_err}, 32'd1);
        chk("ill_res", out_res, 32'd0);
        chk("ill_alu_c", {27'd0, alu_c}, 32'd0);
        chk("ill_alu_a", alu_a, 32'd0);
        chk("ill_flag_reg", {29'd0, flag_reg}, 32'd1);
        handshake("ill");
        chk("ill_err_hold", {31'd0, out_err}, 32'd1);

        issue(3'd0, 32'd1, 32'd1, 16'h0, 1'b0);
        wait_valid("add2_valid", 2);
        chk("add2_res", out_res, 32'd2);
        chk("add2_err", {31'd0, out_err}, 32'd0);
        chk("add2_flag_reg", {29'd0, flag_reg}, 32'd0);
        handshake("add2");

        issue(3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0, 1'b0);
        chk("xor_alu_c", {27'd0, alu_c}, 32'd2);
        rst = 1'b1;
        tick;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst_alu_c", {27'd0, alu_c}, 32'd0);
        rst = 1'b0;
        tick;
        chk("mrst_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_rel_valid", {31'd0, out_valid}, 32'd0);
        tick;
        tick;
        chk("mrst_late_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_flag_reg", {29'd0, flag_reg}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
